line_fill_responder: RTL and testbench



---
 rtl/line_fill_responder_pkg.sv | 26 ++
 rtl/line_fill_responder_mem.sv | 25 ++
 rtl/line_fill_responder.sv | 145 ++++++++++++++
 tb/tb_line_fill_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_responder_pkg.sv
// Shared cache-line geometry and the responder FSM encoding.
// The cache controller imports the same geometry so both sides agree on beat count.
package line_fill_responder_pkg;

   localparam int LINE_SIZE_BYTES = 64;
   localparam int DATA_WIDTH      = 32;
   localparam int ADDRESS_WIDTH   = 32;
   localparam int OFFSET_BITS     = 6;
   localparam int BEATS_PER_LINE  = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
   localparam int WORD_BITS       = $clog2(BEATS_PER_LINE);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_BURST = 3'd2,
      WR_BURST = 3'd3,
      WR_DONE  = 3'd4
   } state_t;

   // Word index of fill beat 'beat' when the burst starts at 'start'; wraps 15 -> 0.
   function automatic logic [WORD_BITS-1:0] wrap_word(input logic [WORD_BITS-1:0] start,
                                                      input logic [WORD_BITS-1:0] beat);
      return start + beat;
   endfunction

endpackage

// File: rtl/line_fill_responder_mem.sv
// Single-port synchronous word RAM addressed by {line, word}.
// Read-first: a write and a read of the same address in one cycle returns the old word.
// Contents and the read register are deliberately not reset.
module line_mem_array #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write on we; always register the addressed word for the next cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side responder for the cache line interface: serves 16-beat line fills
// (critical word first, wrapping) after a programmable latency, and 16-beat
// writebacks starting at word 0.
// Handshakes: a request transfers on req_valid && req_ready, a writeback beat on
// wr_valid && wr_ready, a fill beat on rd_valid && rd_ready; the offering side
// holds its payload stable until the transfer happens.
module line_fill_responder
   import line_fill_responder_pkg::*;
#(
   parameter int MEM_INDEX_BITS = 10,
   parameter int LATENCY        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic                     wr_valid,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     wr_ready,
   output logic                     wr_done,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_last,
   input  logic                     rd_ready,
   output logic                     busy,
   output state_t                   fsm_state
);

   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int RAM_AW = MEM_INDEX_BITS + WORD_BITS;
   localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(LATENCY - 1);
   localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(BEATS_PER_LINE - 1);

   state_t                    state;
   state_t                    next_state;
   logic [MEM_INDEX_BITS-1:0] line_q;
   logic [WORD_BITS-1:0]      start_q;
   logic [WORD_BITS-1:0]      beat;
   logic [CNT_W-1:0]          lat_cnt;
   logic                      accept;
   logic                      rd_fire;
   logic                      wr_fire;
   logic                      ram_we;
   logic [RAM_AW-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0]     ram_rdata;
   logic                      unused_addr_bits;

   // Byte-lane bits and bits above the held line index alias away.
   assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDRESS_WIDTH-1:OFFSET_BITS+MEM_INDEX_BITS]};

   assign accept    = req_valid && req_ready;
   assign rd_fire   = (state == RD_BURST) && rd_ready;
   assign wr_fire   = (state == WR_BURST) && wr_valid;
   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (accept) next_state = req_write ? WR_BURST : RD_WAIT;
         RD_WAIT:  if (lat_cnt == '0) next_state = RD_BURST;
         RD_BURST: if (rd_fire && (beat == LAST_BEAT)) next_state = IDLE;
         WR_BURST: if (wr_fire && (beat == LAST_BEAT)) next_state = WR_DONE;
         WR_DONE:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Request capture, latency countdown, beat counter and registered req_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b0;
         line_q    <= '0;
         start_q   <= '0;
         beat      <= '0;
         lat_cnt   <= '0;
      end else begin
         req_ready <= (next_state == IDLE);
         if (accept) begin
            line_q  <= req_addr[OFFSET_BITS +: MEM_INDEX_BITS];
            start_q <= req_addr[OFFSET_BITS-1:2];
            beat    <= '0;
            lat_cnt <= CNT_LOAD;
         end else if ((state == RD_WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end else if (rd_fire || wr_fire) begin
            beat <= beat + 1'b1;
         end
      end
   end

   // Outputs and RAM control. The RAM is read one cycle ahead: in RD_WAIT it
   // fetches the critical word, in RD_BURST it fetches the next word on a
   // transfer and re-fetches the current word on a stall, so rd_data holds.
   always_comb begin
      wr_ready = 1'b0;
      wr_done  = 1'b0;
      rd_valid = 1'b0;
      rd_data  = '0;
      rd_last  = 1'b0;
      busy     = (state != IDLE);
      ram_we   = 1'b0;
      ram_addr = {line_q, start_q};
      case (state)
         RD_BURST: begin
            rd_valid = 1'b1;
            rd_data  = ram_rdata;
            rd_last  = (beat == LAST_BEAT);
            ram_addr = {line_q, wrap_word(start_q, beat + WORD_BITS'(rd_ready))};
         end
         WR_BURST: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid;
            ram_addr = {line_q, beat};
         end
         WR_DONE: begin
            wr_done = 1'b1;
         end
         default: ;
      endcase
   end

   line_mem_array #(
      .ADDR_W (RAM_AW),
      .DATA_W (DATA_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wr_data),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: writebacks, wrapped fills, stalls,
// ignored requests during a burst, and an asynchronous abort.
module tb_line_fill_responder;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        wr_done;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        rd_ready;
   logic        busy;
   line_fill_responder_pkg::state_t fsm_state;

   int          tests;
   int          fails;
   logic [31:0] exp_q [$];
   logic [31:0] model [int];
   logic [31:0] wbuf  [16];

   line_fill_responder #(
      .MEM_INDEX_BITS (10),
      .LATENCY        (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .wr_done   (wr_done),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .rd_ready  (rd_ready),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_wr_ready"},  {31'd0, wr_ready},  32'd0);
      chk({tag, "_wr_done"},   {31'd0, wr_done},   32'd0);
      chk({tag, "_rd_valid"},  {31'd0, rd_valid},  32'd0);
      chk({tag, "_rd_data"},   rd_data,            32'd0);
      chk({tag, "_rd_last"},   {31'd0, rd_last},   32'd0);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
   endtask

   // Queue the 16 words a fill of addr must return, critical word first.
   task automatic push_exp(input logic [31:0] addr);
      int idx;
      int start;
      idx   = int'(addr[15:6]);
      start = int'(addr[5:2]);
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(model[idx*16 + ((start + k) % 16)]);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic handshake(input logic [31:0] addr, input logic write);
      int b;
      req_valid = 1'b1;
      req_write = write;
      req_addr  = addr;
      b = 0;
      while (!req_ready && b < 50) begin
         @(negedge clk);
         b++;
      end
      chk("req_ready_for_handshake", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic write_line(input logic [31:0] addr);
      int hi;
      int idx;
      idx = int'(addr[15:6]);
      handshake(addr, 1'b1);
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         wr_valid = 1'b1;
         wr_data  = wbuf[k];
         if (wr_ready) hi++;
         model[idx*16 + k] = wbuf[k];
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wr_data  = '0;
      chk("wr_ready_cycles", hi, 32'd16);
      chk("wr_done_pulse", {31'd0, wr_done}, 32'd1);
      chk("wr_ready_low_in_done", {31'd0, wr_ready}, 32'd0);
      chk("req_ready_low_in_done", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("wr_done_single", {31'd0, wr_done}, 32'd0);
      chk("req_ready_after_write", {31'd0, req_ready}, 32'd1);
   endtask

   // Starts at the negedge after the accept edge; consumes max_x fill beats.
   task automatic collect(input logic check_lat, input logic stall, input int max_x,
                          input logic hold_en, input logic [31:0] hold_addr);
      int          lat;
      int          cyc;
      int          xfers;
      logic        stalled;
      logic [31:0] held;
      logic [31:0] expv;
      logic [3:0]  pat;
      pat     = 4'b1001;
      lat     = 0;
      stalled = 1'b0;
      held    = '0;
      while (!rd_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (check_lat) chk("first_rd_valid_latency", lat, LAT);
      cyc   = 0;
      xfers = 0;
      while (xfers < max_x && cyc < 400) begin
         chk("rd_valid_in_burst", {31'd0, rd_valid}, 32'd1);
         chk("req_ready_low_in_burst", {31'd0, req_ready}, 32'd0);
         if (stalled) chk("rd_data_stable_in_stall", rd_data, held);
         rd_ready = stall ? pat[cyc % 4] : 1'b1;
         if (rd_ready) begin
            if (exp_q.size() == 0) begin
               chk("exp_q_underflow", exp_q.size(), 32'd1);
               expv = '0;
            end else begin
               expv = exp_q.pop_front();
            end
            chk("rd_data", rd_data, expv);
            chk("rd_last", {31'd0, rd_last}, {31'd0, (xfers == 15)});
            xfers++;
            stalled = 1'b0;
         end else begin
            held    = rd_data;
            stalled = 1'b1;
         end
         if (hold_en && xfers >= 8) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = hold_addr;
         end
         cyc++;
         @(negedge clk);
      end
      rd_ready = 1'b1;
      chk("burst_transfers", xfers, max_x);
      if (max_x == 16) begin
         chk("rd_valid_after_last", {31'd0, rd_valid}, 32'd0);
         chk("req_ready_after_last", {31'd0, req_ready}, 32'd1);
         chk("busy_after_last", {31'd0, busy}, 32'd0);
         chk("exp_q_drained", exp_q.size(), 32'd0);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_ready  = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      chk("fsm_idle_in_reset", {29'd0, fsm_state}, {29'd0, line_fill_responder_pkg::IDLE});
      rst = 1'b0;
      #1;
      chk("req_ready_at_release", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

      // Writeback of line 0x1240 with 0xA000_0000+k.
      for (int k = 0; k < 16; k++) wbuf[k] = 32'hA000_0000 + 32'(k);
      write_line(32'h0000_1240);

      // Writeback beats while idle must be ignored.
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         chk("wr_ready_low_idle", {31'd0, wr_ready}, 32'd0);
      end
      wr_valid = 1'b0;

      // Fill from word 0 with latency check.
      push_exp(32'h0000_1240);
      handshake(32'h0000_1240, 1'b0);
      collect(1'b1, 1'b0, 16, 1'b0, 32'd0);

      // Fill from word 13, wrapping.
      push_exp(32'h0000_1274);
      handshake(32'h0000_1274, 1'b0);
      collect(1'b1, 1'b0, 16, 1'b0, 32'd0);

      // Same fill with rd_ready pattern 1,0,0,1.
      push_exp(32'h0000_1274);
      handshake(32'h0000_1274, 1'b0);
      collect(1'b1, 1'b1, 16, 1'b0, 32'd0);

      // Request held during a burst is accepted only once IDLE returns.
      push_exp(32'h0000_1240);
      handshake(32'h0000_1240, 1'b0);
      collect(1'b1, 1'b0, 16, 1'b1, 32'h0000_1274);
      push_exp(32'h0000_1274);
      @(negedge clk);
      req_valid = 1'b0;
      chk("held_req_accepted_busy", {31'd0, busy}, 32'd1);
      chk("held_req_accepted_ready", {31'd0, req_ready}, 32'd0);
      collect(1'b1, 1'b0, 16, 1'b0, 32'd0);

      // Random line, read back through an aliased address starting at word 2.
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom_range(32'h7FFF_FFFF, 0) ^ 32'(k << 28);
      write_line(32'h0000_2380);
      push_exp(32'hFFFF_2388);
      handshake(32'hFFFF_2388, 1'b0);
      collect(1'b1, 1'b0, 16, 1'b0, 32'd0);

      // Asynchronous reset at beat 7 of a fill.
      push_exp(32'h0000_1274);
      handshake(32'h0000_1274, 1'b0);
      collect(1'b0, 1'b0, 7, 1'b0, 32'd0);
      exp_q.delete();
      #2 rst = 1'b1;
      #1;
      chk_outputs_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_abort", {31'd0, req_ready}, 32'd1);
      push_exp(32'h0000_1240);
      handshake(32'h0000_1240, 1'b0);
      collect(1'b1, 1'b0, 16, 1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
